// File: rtl/div_sequencer_pkg.sv
// ============================================================================
// Module : mips_pkg
// Brief  : Shared constants and divider state encoding for the MIPS core.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_RUN  = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = DIV_IDLE,
    S_RUN  = DIV_RUN,
    S_DONE = DIV_DONE
  } divState_t;

endpackage

`default_nettype wire

// File: rtl/div_sequencer_step.sv
// ============================================================================
// Module : div_step
// Brief  : One combinational radix-2 restoring-division iteration.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_step
  import mips_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvsr,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_remShift;
  logic [WIDTH:0] w_trial;

  // Remainder is carried one bit wider so 2*rem+1 never overflows before the subtract.
  assign w_remShift = {i_rem, i_quo[WIDTH-1]};
  assign w_trial    = w_remShift - {1'b0, i_dvsr};

  assign o_rem = w_trial[WIDTH] ? w_remShift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], ~w_trial[WIDTH]};

endmodule

`default_nettype wire

// File: rtl/div_sequencer.sv
// ============================================================================
// Module : div_sequencer
// Brief  : Multi-cycle DIV/DIVU unit with HiLo write strobe and pipeline stall.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_sequencer
  import mips_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               mf_req,
  output logic               busy,
  output logic               stall,
  output logic               hilo_we,
  output logic [2*WIDTH-1:0] div_ans,
  output logic               div_by_zero
);

  divState_t        r_state, w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvsr;
  logic             r_negQ, r_negR, r_dbz;
  logic [2*WIDTH-1:0] r_ans;

  logic             w_sgnA, w_sgnB, w_zeroDvsr;
  logic [WIDTH-1:0] w_absA, w_absB;
  logic [WIDTH-1:0] w_stepRem, w_stepQuo;
  logic [WIDTH-1:0] w_fixRem, w_fixQuo;

  assign w_sgnA     = is_signed & dividend[WIDTH-1];
  assign w_sgnB     = is_signed & divisor[WIDTH-1];
  assign w_absA     = w_sgnA ? -dividend : dividend;
  assign w_absB     = w_sgnB ? -divisor  : divisor;
  assign w_zeroDvsr = (divisor == '0);

  assign w_fixQuo = r_negQ ? -r_quo : r_quo;
  assign w_fixRem = r_negR ? -r_rem : r_rem;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_quo  (r_quo),
    .i_dvsr (r_dvsr),
    .o_rem  (w_stepRem),
    .o_quo  (w_stepQuo)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    hilo_we     = 1'b0;
    div_ans     = r_ans;
    case (r_state)
      S_IDLE: if (start) w_nextState = w_zeroDvsr ? S_DONE : S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (r_cnt == CNT_W'(1)) w_nextState = S_DONE;
      end
      S_DONE: begin
        busy        = 1'b1;
        hilo_we     = 1'b1;
        div_ans     = {w_fixRem, w_fixQuo};
        w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
    stall = busy & (mf_req | start);
  end

  // Divide-by-zero preloads its fixed result and zero sign flags so DONE passes it through.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvsr <= '0;
      r_negQ <= 1'b0;
      r_negR <= 1'b0;
      r_dbz  <= 1'b0;
      r_ans  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_cnt  <= CNT_W'(WIDTH);
          r_dvsr <= w_absB;
          if (w_zeroDvsr) begin
            r_rem  <= dividend;
            r_quo  <= '1;
            r_negQ <= 1'b0;
            r_negR <= 1'b0;
            r_dbz  <= 1'b1;
          end else begin
            r_rem  <= '0;
            r_quo  <= w_absA;
            r_negQ <= w_sgnA ^ w_sgnB;
            r_negR <= w_sgnA;
            r_dbz  <= 1'b0;
          end
        end
        S_RUN: begin
          r_rem <= w_stepRem;
          r_quo <= w_stepQuo;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_DONE:  r_ans <= {w_fixRem, w_fixQuo};
        default: ;
      endcase
    end
  end

  assign div_by_zero = r_dbz;

endmodule

`default_nettype wire
